axis_add_stage: RTL and testbench
=================================

Name: axis_add_stage

Overview:
- AXI4-Stream pipeline stage that applies the example_pkg arithmetic (pass, add_one, add_two) to every 32-bit beat. It sits downstream of the stimulus master and upstream of the DUT stream slave in the example testbench.
- Provides a registered, full-throughput valid/ready boundary: one output register plus one skid register.
- Adds saturating beat and packet statistics counters for the checker.

Parameters:
- DATA_W, 32, tdata width; only 32 is supported, which matches the package functions.
- CNT_W, 16, width of the statistics counters.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  stage can accept a beat.
- s_axis_tdata  in  DATA_W  upstream data.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tdata  out  DATA_W  transformed data.
- m_axis_tlast  out  1  forwarded tlast.
- cfg_mode  in  2  0=pass, 1=add_one, 2=add_two, 3=reserved (treated as pass).
- stat_clear  in  1  synchronous clear of both counters.
- stat_beats  out  CNT_W  output beats transferred.
- stat_pkts  out  CNT_W  output packets transferred (beats with tlast).

Behaviour:
- Reset: one clock (aclk); aresetn is asynchronous and active-low, asserted asynchronously and released synchronously to aclk.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0.
  - stat_beats=0, stat_pkts=0.
  - FSM in EMPTY, in_pkt=0, pkt_mode=0.
- s_axis_tready goes to 1 on the first rising edge after reset release.
- Handshakes:
  - Input accept = s_axis_tvalid & s_axis_tready.
  - Output transfer = m_axis_tvalid & m_axis_tready.
  - Once m_axis_tvalid is asserted, it and data/last are held until the transfer.
- Latency: an accepted beat appears on m_axis one cycle after acceptance. Throughput is 1 beat/cycle when m_axis_tready=1.
- Transform is computed on the input side, before registering, and is stored in the output or skid register:
  - mode 1: data+1 mod 2^32.
  - mode 2: data+2 mod 2^32.
  - mode 0/3: data unchanged.
- Wrap-around cases:
  - 0xFFFFFFFF+1 = 0x00000000.
  - 0xFFFFFFFE+2 = 0x00000000.
  - 0xFFFFFFFF+2 = 0x00000001.
- Mode latching:
  - On an accepted beat with in_pkt=0, pkt_mode is set from cfg_mode and used for that beat.
  - in_pkt=1 after an accepted non-last beat; in_pkt=0 after an accepted last beat.
  - cfg_mode changes mid-packet are ignored until the next packet.
  - A single-beat packet (tlast on the first beat) uses cfg_mode of that cycle.
- FSM, registered s_axis_tready = (state != FULL):
  - EMPTY:
    - accept -> BUSY (load output register).
  - BUSY:
    - accept & transfer -> BUSY (reload output register).
    - accept & !transfer -> FULL (load skid register).
    - !accept & transfer -> EMPTY.
  - FULL:
    - transfer -> BUSY (skid register moves to output register).
    - No accept is possible in FULL.
- Ordering: beats leave in arrival order; no beat is duplicated or dropped.
- Counters:
  - On transfer: stat_beats+1; if tlast, also stat_pkts+1.
  - Both counters saturate at 2^CNT_W-1.
  - stat_clear has priority: clear and an increment in the same cycle gives 0.
- Reset mid-operation: in-flight output and skid beats are discarded, and in_pkt and the counters are cleared immediately (asynchronously).
- tdata and tlast are ignored when s_axis_tvalid=0.

Test Plan:
- Mode 1, m_axis_tready=1, beats 0x0,0x10,0xFFFFFFFF (last on 3rd) -> outputs 0x1,0x11,0x0 one cycle after each accept; stat_beats=3, stat_pkts=1.
- Mode 2 set on beat 1 of a 4-beat packet, cfg_mode switched to 0 at beat 2 -> all four beats get +2 (0xFFFFFFFE->0x0); the next packet uses mode 0.
- Backpressure: continuous input, m_axis_tready low for 3 cycles -> s_axis_tready drops after exactly 2 buffered beats, m_axis_tvalid/tdata stay stable, order is preserved, no loss.
- Random tvalid and tready with 1000 beats in mode 1 -> scoreboard matches input+1 in order; stat_beats=1000.
- Preload stat_beats to 0xFFFF via 65535 beats, then one more beat plus stat_clear in the same cycle -> counter saturates at 0xFFFF, then reads 0 after the clear cycle.
- aresetn pulsed low while in FULL -> m_axis_tvalid=0 asynchronously and the counters read 0; after release s_axis_tready=1 on the first edge and the next packet re-latches cfg_mode.

Source files
------------

// File: rtl/axis_add_stage.sv
// AXI4-Stream stage: per-packet add_one/add_two/pass transform with an output
// register plus skid register, and saturating beat/packet statistics.
module axis_add_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic [1:0]        cfg_mode,
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  stat_beats,
  output logic [CNT_W-1:0]  stat_pkts
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t            state, next_state;
  logic              ready_q;
  logic              in_pkt;
  logic [1:0]        pkt_mode;
  logic [1:0]        eff_mode;
  logic [DATA_W-1:0] out_data, skid_data, xform_data;
  logic              out_last, skid_last;
  logic              accept, transfer;
  logic              load_out_in, load_skid, load_out_skid;

  assign accept        = s_axis_tvalid & ready_q;
  assign transfer      = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;

  // The first beat of a packet uses the live cfg_mode; later beats reuse the latched one.
  always_comb begin
    eff_mode = in_pkt ? pkt_mode : cfg_mode;
    case (eff_mode)
      2'd1:    xform_data = s_axis_tdata + DATA_W'(1);
      2'd2:    xform_data = s_axis_tdata + DATA_W'(2);
      default: xform_data = s_axis_tdata;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != FULL);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (accept) next_state = BUSY;
      BUSY: begin
        if (accept && !transfer)      next_state = FULL;
        else if (!accept && transfer) next_state = EMPTY;
      end
      FULL:    if (transfer) next_state = BUSY;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state != EMPTY);
    load_out_in   = accept && ((state == EMPTY) || ((state == BUSY) && transfer));
    load_skid     = accept && (state == BUSY) && !transfer;
    load_out_skid = (state == FULL) && transfer;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_data <= xform_data;
        out_last <= s_axis_tlast;
      end else if (load_out_skid) begin
        out_data <= skid_data;
        out_last <= skid_last;
      end
      if (load_skid) begin
        skid_data <= xform_data;
        skid_last <= s_axis_tlast;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_pkt   <= 1'b0;
      pkt_mode <= 2'd0;
    end else if (accept) begin
      if (!in_pkt) pkt_mode <= cfg_mode;
      in_pkt <= !s_axis_tlast;
    end
  end

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (stat_clear) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (transfer) begin
      if (stat_beats != {CNT_W{1'b1}}) stat_beats <= stat_beats + CNT_W'(1);
      if (m_axis_tlast && (stat_pkts != {CNT_W{1'b1}})) stat_pkts <= stat_pkts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_add_stage.sv
// Directed bench for axis_add_stage: transforms, mode latching, backpressure,
// random-handshake scoreboard, counter saturation/clear and mid-flight reset.
module tb_axis_add_stage;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [1:0]  cfg_mode;
  logic        stat_clear;
  logic [15:0] stat_beats, stat_pkts;

  int total = 0;
  int bad   = 0;

  logic [31:0] vin  [8];
  logic [31:0] vexp [8];
  logic        vlast[8];
  logic [1:0]  vmode[8];
  logic [32:0] sb[$];

  always #5 aclk = ~aclk;

  axis_add_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .cfg_mode(cfg_mode), .stat_clear(stat_clear),
    .stat_beats(stat_beats), .stat_pkts(stat_pkts)
  );

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                               input logic [1:0] m, input logic r);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    cfg_mode      = m;
    m_axis_tready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int sent, recv, cyc, exp_pkts;
    logic hold;
    logic [32:0] exp_beat;

    // Directed table: beats 0-2 are the mode-1 packet, 3-6 a mode-2 packet with
    // cfg_mode dropped to 0 mid-packet, 7 a single-beat mode-0 packet.
    vin   = '{32'h0, 32'h10, 32'hFFFF_FFFF, 32'h100, 32'h200, 32'hFFFF_FFFE, 32'h7, 32'h55};
    vexp  = '{32'h1, 32'h11, 32'h0,         32'h102, 32'h202, 32'h0,         32'h9, 32'h55};
    vlast = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vmode = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};

    aresetn    = 1'b0;
    stat_clear = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
    repeat (3) @(negedge aclk);
    checkOutput("rst_m_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("rst_m_tdata", m_axis_tdata, 32'h0);
    checkOutput("rst_m_tlast", m_axis_tlast, 1'b0);
    checkOutput("rst_s_tready", s_axis_tready, 1'b0);
    checkOutput("rst_stat_beats", stat_beats, 16'h0);
    checkOutput("rst_stat_pkts", stat_pkts, 16'h0);
    aresetn = 1'b1;
    #1 checkOutput("release_s_tready_low", s_axis_tready, 1'b0);
    @(negedge aclk);
    checkOutput("release_s_tready_high", s_axis_tready, 1'b1);

    $display("[TB] mode 1 packet with wrap");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, vin[i], vlast[i], vmode[i], 1'b1);
      @(negedge aclk);
      checkOutput($sformatf("vec%0d_valid", i), m_axis_tvalid, 1'b1);
      checkOutput($sformatf("vec%0d_data", i), m_axis_tdata, vexp[i]);
      checkOutput($sformatf("vec%0d_last", i), m_axis_tlast, vlast[i]);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd1, 1'b1);
    @(negedge aclk);
    checkOutput("t1_drained", m_axis_tvalid, 1'b0);
    checkOutput("t1_stat_beats", stat_beats, 16'd3);
    checkOutput("t1_stat_pkts", stat_pkts, 16'd1);

    stat_clear = 1'b1;
    @(negedge aclk);
    stat_clear = 1'b0;
    checkOutput("clear_beats", stat_beats, 16'd0);
    checkOutput("clear_pkts", stat_pkts, 16'd0);

    $display("[TB] mode latching across a packet");
    for (int i = 3; i < 8; i++) begin
      applyStimulus(1'b1, vin[i], vlast[i], vmode[i], 1'b1);
      @(negedge aclk);
      checkOutput($sformatf("vec%0d_valid", i), m_axis_tvalid, 1'b1);
      checkOutput($sformatf("vec%0d_data", i), m_axis_tdata, vexp[i]);
      checkOutput($sformatf("vec%0d_last", i), m_axis_tlast, vlast[i]);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("t2_drained", m_axis_tvalid, 1'b0);
    checkOutput("t2_stat_beats", stat_beats, 16'd5);
    checkOutput("t2_stat_pkts", stat_pkts, 16'd2);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'hA0, 1'b0, 2'd0, 1'b0);
    @(negedge aclk);
    checkOutput("bp_a1_valid", m_axis_tvalid, 1'b1);
    checkOutput("bp_a1_data", m_axis_tdata, 32'hA0);
    checkOutput("bp_a1_ready", s_axis_tready, 1'b1);
    applyStimulus(1'b1, 32'hA1, 1'b0, 2'd0, 1'b0);
    @(negedge aclk);
    checkOutput("bp_a2_ready", s_axis_tready, 1'b0);
    checkOutput("bp_a2_data", m_axis_tdata, 32'hA0);
    applyStimulus(1'b1, 32'hA2, 1'b0, 2'd0, 1'b0);
    @(negedge aclk);
    checkOutput("bp_a3_ready", s_axis_tready, 1'b0);
    checkOutput("bp_a3_valid", m_axis_tvalid, 1'b1);
    checkOutput("bp_a3_data", m_axis_tdata, 32'hA0);
    applyStimulus(1'b1, 32'hA2, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("bp_a4_data", m_axis_tdata, 32'hA1);
    checkOutput("bp_a4_ready", s_axis_tready, 1'b1);
    applyStimulus(1'b1, 32'hA2, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("bp_a5_data", m_axis_tdata, 32'hA2);
    applyStimulus(1'b1, 32'hA3, 1'b1, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("bp_a6_data", m_axis_tdata, 32'hA3);
    checkOutput("bp_a6_last", m_axis_tlast, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("bp_a7_valid", m_axis_tvalid, 1'b0);

    $display("[TB] random handshakes, mode 1");
    stat_clear = 1'b1;
    @(negedge aclk);
    stat_clear = 1'b0;
    sent = 0; recv = 0; cyc = 0; exp_pkts = 0; hold = 1'b0;
    cfg_mode = 2'd1;
    while (recv < 1000 && cyc < 20000) begin
      if (!hold) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = $urandom;
          s_axis_tlast  = (sent == 999) || ($urandom_range(0, 7) == 0);
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      m_axis_tready = ($urandom_range(0, 2) != 0);
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checkOutput("rand_unexpected_beat", {m_axis_tlast, m_axis_tdata}, 33'h0);
        end else begin
          exp_beat = sb.pop_front();
          checkOutput("rand_beat", {m_axis_tlast, m_axis_tdata}, exp_beat);
        end
        recv++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        sb.push_back({s_axis_tlast, s_axis_tdata + 32'd1});
        if (s_axis_tlast) exp_pkts++;
        sent++;
        hold = 1'b0;
      end else begin
        hold = s_axis_tvalid;
      end
      cyc++;
      @(negedge aclk);
    end
    checkOutput("rand_recv_count", recv, 1000);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd1, 1'b1);
    repeat (2) @(negedge aclk);
    checkOutput("rand_stat_beats", stat_beats, 16'd1000);
    checkOutput("rand_stat_pkts", stat_pkts, exp_pkts);

    $display("[TB] counter saturation and clear");
    applyStimulus(1'b1, 32'h1234, 1'b1, 2'd0, 1'b1);
    repeat (65535) @(negedge aclk);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("sat_preload_beats", stat_beats, 16'hFFFF);
    checkOutput("sat_preload_pkts", stat_pkts, 16'hFFFF);
    applyStimulus(1'b1, 32'h1, 1'b1, 2'd0, 1'b1);
    @(negedge aclk);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("sat_hold_beats", stat_beats, 16'hFFFF);
    checkOutput("sat_hold_pkts", stat_pkts, 16'hFFFF);
    applyStimulus(1'b1, 32'h2, 1'b1, 2'd0, 1'b1);
    @(negedge aclk);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    stat_clear = 1'b1;
    @(negedge aclk);
    stat_clear = 1'b0;
    checkOutput("sat_clear_beats", stat_beats, 16'h0);
    checkOutput("sat_clear_pkts", stat_pkts, 16'h0);

    $display("[TB] reset while FULL");
    applyStimulus(1'b1, 32'h10, 1'b1, 2'd2, 1'b1);
    @(negedge aclk);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd2, 1'b1);
    @(negedge aclk);
    checkOutput("pre_reset_beats", stat_beats, 16'd1);
    applyStimulus(1'b1, 32'h20, 1'b0, 2'd2, 1'b0);
    @(negedge aclk);
    applyStimulus(1'b1, 32'h30, 1'b0, 2'd2, 1'b0);
    @(negedge aclk);
    checkOutput("full_s_tready", s_axis_tready, 1'b0);
    checkOutput("full_m_tdata", m_axis_tdata, 32'h22);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd1, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("async_rst_m_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("async_rst_m_tdata", m_axis_tdata, 32'h0);
    checkOutput("async_rst_beats", stat_beats, 16'h0);
    checkOutput("async_rst_s_tready", s_axis_tready, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("rerelease_s_tready", s_axis_tready, 1'b1);
    checkOutput("rerelease_m_tvalid", m_axis_tvalid, 1'b0);
    applyStimulus(1'b1, 32'h5, 1'b0, 2'd1, 1'b1);
    @(negedge aclk);
    checkOutput("relatch_b0_data", m_axis_tdata, 32'h6);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 2'd3, 1'b1);
    @(negedge aclk);
    checkOutput("relatch_b1_data", m_axis_tdata, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 2'd3, 1'b1);
    @(negedge aclk);
    checkOutput("mode3_pass_data", m_axis_tdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 2'd2, 1'b1);
    @(negedge aclk);
    checkOutput("mode2_wrap_data", m_axis_tdata, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    @(negedge aclk);
    checkOutput("final_beats", stat_beats, 16'd4);
    checkOutput("final_pkts", stat_pkts, 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
